addr4u_stream_acc: RTL
======================

ADDR4U_STREAM_ACC -- requirements
Module: addr4u_stream_acc

Interface
REQ-001 Parameter ACC_W, default 10: accumulator width in bits, legal range 6..16.
REQ-002 Parameter LEN_W, default 8: burst beat-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a  input  4  unsigned operand A.
REQ-008 in_b  input  4  unsigned operand B.
REQ-009 in_last  input  1  marks final beat of a burst.
REQ-010 out_valid  output  1  per-beat sum available.
REQ-011 out_ready  input  1  consumer accepts per-beat sum.
REQ-012 out_sum  output  5  per-beat unsigned sum {carry, sum[3:0]}.
REQ-013 out_err  output  1  per-beat mismatch flag travelling with out_sum.
REQ-014 acc_done  output  1  one-cycle pulse: burst total valid.
REQ-015 acc_sum  output  ACC_W  burst total, saturating.
REQ-016 acc_len  output  LEN_W  number of beats in burst, saturating.
REQ-017 err_sticky  output  1  set on any mismatch, cleared only by reset.

Function
REQ-018 Input transfer occurs only on a cycle with in_valid=1 and in_ready=1.
REQ-019 Each accepted pair shall be summed by the addr4u_core instance; the 5-bit result and a check result (core output != in_a+in_b, computed 5-bit) shall be written into a 2-entry output FIFO on the same edge.
REQ-020 Latency from input transfer to out_valid shall be exactly 1 cycle when FIFO was empty.
REQ-021 out_valid = FIFO non-empty; out_sum/out_err show the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-022 in_ready = FIFO not full, registered-state only; no combinational path from out_ready to in_ready.
REQ-023 Push and pop in the same cycle shall leave occupancy unchanged and preserve order; on full FIFO only pop occurs.
REQ-024 Any out_err=1 entry written shall set err_sticky on the same edge.
REQ-025 FSM states: IDLE (no beat pending in burst), BURST (≥1 beat accepted, no last), DONE (one cycle after last beat accepted).
REQ-026 IDLE->BURST on transfer with in_last=0; IDLE->DONE on transfer with in_last=1; BURST->DONE on transfer with in_last=1; DONE->IDLE if no transfer, DONE->BURST or DONE->DONE on transfer per in_last; otherwise hold.
REQ-027 Running accumulator adds the core sum (zero-extended) each transfer, saturating at 2^ACC_W-1; beat counter increments, saturating at 2^LEN_W-1.
REQ-028 On the transfer carrying in_last, acc_sum/acc_len shall latch the final total/count (including that beat) and acc_done shall be 1 in the following cycle only (state DONE).
REQ-029 Running accumulator and counter shall restart from the beat accepted in DONE, not from stale totals; acc_sum/acc_len hold until next latch.
REQ-030 Burst tracking is independent of output backpressure; acc_done does not wait for the FIFO to drain.

Reset
REQ-031 rst asserted: FIFO empty, in_ready=0 while rst=1 then 1 the first cycle after release, out_valid=0, out_sum=0, out_err=0, acc_done=0, acc_sum=0, acc_len=0, err_sticky=0, FSM=IDLE, accumulator/counter=0.
REQ-032 Reset mid-burst discards partial total and FIFO contents; no acc_done shall be produced for the aborted burst.

Structure
REQ-033 Shared package holds the FSM state enum (IDLE, BURST, DONE), FIFO depth constant 2, and the 5-bit sum width constant.
REQ-034 One sub-module: addr4u_core, the purely combinational 4-bit unsigned adder (A,B -> 5-bit O), instantiated once; all sequential logic resides in addr4u_stream_acc.

Verification
REQ-035 Single beat a=9,b=8,last=1, out_ready=1 -> next cycle out_valid=1, out_sum=17, out_err=0; acc_done=1, acc_sum=17, acc_len=1.
REQ-036 Burst of 3 beats (15+15, 1+2, 0+0 last) back-to-back, out_ready=1 -> out_sum 30,3,0 in order; acc_done one cycle after beat 3, acc_sum=33, acc_len=3.
REQ-037 out_ready=0, push 3 beats -> in_ready falls after 2 accepted; third held; release out_ready -> all 3 sums emerge in order, none lost or duplicated.
REQ-038 ACC_W=6, 4 beats of 15+15 with last -> acc_sum=63 (saturated), acc_len=4.
REQ-039 Force core output bit to wrong value on one beat -> that beat out_err=1, err_sticky=1 persisting until rst.
REQ-040 Assert rst after 2 beats of a burst without last -> all outputs zero, no acc_done; new burst 1+1 last -> acc_sum=2, acc_len=1.

Source files
------------

// File: rtl/addr4u_stream_acc_pkg.sv
// Shared definitions for the addr4u streaming accumulator.
//   state_t      : burst-tracking FSM states (IDLE, BURST, DONE)
//   FIFO_DEPTH   : depth of the per-beat output FIFO
//   SUM_W        : width of one per-beat sum {carry, sum[3:0]}
//   fifo_entry_t : one FIFO slot, the sum plus its mismatch flag
package addr4u_stream_acc_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int SUM_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic             err;
        logic [SUM_W-1:0] sum;
    } fifo_entry_t;

endpackage

// File: rtl/addr4u_core.sv
// Purely combinational 4-bit unsigned adder.
//   a, b : 4-bit unsigned operands
//   o    : 5-bit result {carry, sum[3:0]}
module addr4u_core
    import addr4u_stream_acc_pkg::*;
(
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [SUM_W-1:0] o
);

    assign o = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/addr4u_stream_acc.sv
// Streaming 4-bit adder with a 2-entry per-beat output FIFO and a
// saturating per-burst accumulator.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake; in_a, in_b operands, in_last ends a burst
//   out_valid/out_ready : per-beat result handshake; out_sum, out_err head entry
//   acc_done            : one-cycle pulse, acc_sum/acc_len hold the last burst total
//   err_sticky          : set by any mismatched beat, cleared only by reset
//   dbg_state           : current burst FSM state
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. in_ready is a register derived from the FIFO
// occupancy, so it never depends combinationally on out_ready.
module addr4u_stream_acc
    import addr4u_stream_acc_pkg::*;
#(
    parameter int ACC_W = 10,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_err,
    output logic             acc_done,
    output logic [ACC_W-1:0] acc_sum,
    output logic [LEN_W-1:0] acc_len,
    output logic             err_sticky,
    output state_t           dbg_state
);

    // ---------------- adder and self-check ----------------
    logic [SUM_W-1:0] core_sum;
    logic [SUM_W-1:0] ref_sum;
    logic             chk_err;

    addr4u_core u_core (
        .a (in_a),
        .b (in_b),
        .o (core_sum)
    );

    // Independent reference sum; a disagreement flags a faulty core.
    assign ref_sum = {1'b0, in_a} + {1'b0, in_b};
    assign chk_err = (core_sum != ref_sum);

    // ---------------- output FIFO ----------------
    fifo_entry_t mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        in_ready_q;
    logic        push;
    logic        pop;
    fifo_entry_t head;

    assign in_ready  = in_ready_q;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_sum   = out_valid ? head.sum : '0;
    assign out_err   = out_valid ? head.err : 1'b0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{err: chk_err, sum: core_sum};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
            // Ready for the next cycle is decided from next occupancy only.
            in_ready_q <= (count_next != 2'(FIFO_DEPTH));
            if (push && chk_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // ---------------- burst FSM ----------------
    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (push) state_next = in_last ? DONE : BURST;
            end
            BURST: begin
                if (push && in_last) state_next = DONE;
            end
            DONE: begin
                if (push) state_next = in_last ? DONE : BURST;
                else      state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_done  = (state == DONE);
        dbg_state = state;
    end

    // ---------------- running accumulator ----------------
    // Only BURST carries a partial total forward; a beat accepted in IDLE
    // or DONE starts a fresh burst, so stale running values are ignored.
    logic [ACC_W-1:0] run_acc;
    logic [LEN_W-1:0] run_len;
    logic [ACC_W-1:0] base_acc;
    logic [LEN_W-1:0] base_len;
    logic [ACC_W:0]   acc_wide;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] len_next;

    always_comb begin
        base_acc = (state == BURST) ? run_acc : '0;
        base_len = (state == BURST) ? run_len : '0;
        acc_wide = {1'b0, base_acc} + {{(ACC_W+1-SUM_W){1'b0}}, core_sum};
        acc_next = acc_wide[ACC_W] ? {ACC_W{1'b1}} : acc_wide[ACC_W-1:0];
        len_next = (base_len == {LEN_W{1'b1}}) ? base_len : base_len + LEN_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_acc <= '0;
            run_len <= '0;
            acc_sum <= '0;
            acc_len <= '0;
        end else if (push) begin
            run_acc <= acc_next;
            run_len <= len_next;
            if (in_last) begin
                acc_sum <= acc_next;
                acc_len <= len_next;
            end
        end
    end

endmodule
